// File: rtl/fb_scaled_reader.sv
// Display-side framebuffer reader: centred window address generation and 2-cycle colour return.
// Optional FB_BORDER_EN draws a 1-pixel 8'hFF ring just outside the image window.
module fb_scaled_reader #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int FATOR    = 2,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        next_x,
    input  logic [9:0]        next_y,
    input  logic [1:0]        seletor,
    input  logic              copy_done,
    input  logic [7:0]        ram_q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        color_out,
    output logic              frame_active,
    output logic [3:0]        dbg_o
);

    // Handshake: none; next_x/next_y are consumed every clock, colour returns 2 clocks later.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        SHOW       = 2'd2
    } state_t;

    localparam logic [9:0] W_BIG   = 10'(IMG_W * FATOR);
    localparam logic [9:0] H_BIG   = 10'(IMG_H * FATOR);
    localparam logic [9:0] W_SMALL = 10'(IMG_W / FATOR);
    localparam logic [9:0] H_SMALL = 10'(IMG_H / FATOR);
    localparam logic [9:0] W_NAT   = 10'(IMG_W);
    localparam logic [9:0] H_NAT   = 10'(IMG_H);
    localparam logic [9:0] XO_BIG   = 10'((H_ACTIVE - IMG_W * FATOR) / 2);
    localparam logic [9:0] YO_BIG   = 10'((V_ACTIVE - IMG_H * FATOR) / 2);
    localparam logic [9:0] XO_SMALL = 10'((H_ACTIVE - IMG_W / FATOR) / 2);
    localparam logic [9:0] YO_SMALL = 10'((V_ACTIVE - IMG_H / FATOR) / 2);
    localparam logic [9:0] XO_NAT   = 10'((H_ACTIVE - IMG_W) / 2);
    localparam logic [9:0] YO_NAT   = 10'((V_ACTIVE - IMG_H) / 2);

    function automatic logic [9:0] win_w(input logic [1:0] m);
        case (m)
            2'b00:   win_w = W_BIG;
            2'b01:   win_w = W_SMALL;
            default: win_w = W_NAT;
        endcase
    endfunction

    function automatic logic [9:0] win_h(input logic [1:0] m);
        case (m)
            2'b00:   win_h = H_BIG;
            2'b01:   win_h = H_SMALL;
            default: win_h = H_NAT;
        endcase
    endfunction

    function automatic logic [9:0] off_x(input logic [1:0] m);
        case (m)
            2'b00:   off_x = XO_BIG;
            2'b01:   off_x = XO_SMALL;
            default: off_x = XO_NAT;
        endcase
    endfunction

    function automatic logic [9:0] off_y(input logic [1:0] m);
        case (m)
            2'b00:   off_y = YO_BIG;
            2'b01:   off_y = YO_SMALL;
            default: off_y = YO_NAT;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          mode_lat_q, mode_lat_d;
    logic [9:0]          x_off_q, y_off_q;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                in_d1_q, in_d1_d;
    logic                in_d2_q, in_d2_d;
    logic [7:0]          color_q, color_d;

    logic [9:0]  w_amp, h_amp;
    logic [10:0] nx, ny, xo, yo, x_end, y_end;
    logic        in_img, is_first, is_last, fs, leave, show_ok;

    assign w_amp  = win_w(mode_lat_q);
    assign h_amp  = win_h(mode_lat_q);
    assign nx     = {1'b0, next_x};
    assign ny     = {1'b0, next_y};
    assign xo     = {1'b0, x_off_q};
    assign yo     = {1'b0, y_off_q};
    assign x_end  = xo + {1'b0, w_amp};
    assign y_end  = yo + {1'b0, h_amp};

    assign in_img   = (nx >= xo) && (nx < x_end) && (ny >= yo) && (ny < y_end);
    assign is_first = (nx == xo);
    assign is_last  = (nx == x_end - 11'd1);
    assign fs       = (next_x == 10'd0) && (next_y == 10'd0);

    // Any mode change or loss of copy_done drops the display in the same cycle.
    assign leave   = (state_q == SHOW) && ((seletor != mode_lat_q) || !copy_done);
    assign show_ok = (state_q == SHOW) && !leave;

`ifdef FB_BORDER_EN
    logic bd1_q, bd1_d;
    logic in_ext, on_ring, border;

    // Extended box compared as nx+1 >= xo so an offset of zero does not underflow.
    assign in_ext  = (nx + 11'd1 >= xo) && (nx <= x_end) && (ny + 11'd1 >= yo) && (ny <= y_end);
    assign on_ring = (nx + 11'd1 == xo) || (nx == x_end) || (ny + 11'd1 == yo) || (ny == y_end);
    assign border  = in_ext && on_ring;
`endif

    always_comb begin
        state_d    = state_q;
        mode_lat_d = mode_lat_q;
        row_base_d = row_base_q;
        rd_addr_d  = '0;
        in_d1_d    = 1'b0;
        in_d2_d    = in_d1_q;
        color_d    = 8'h00;
`ifdef FB_BORDER_EN
        bd1_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                row_base_d = '0;
                if (copy_done) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                row_base_d = '0;
                if (!copy_done) begin
                    state_d = IDLE;
                end else if (fs) begin
                    mode_lat_d = seletor;
                    state_d    = SHOW;
                end
            end
            SHOW: begin
                if (leave) begin
                    state_d    = IDLE;
                    row_base_d = '0;
                    in_d2_d    = 1'b0;
                end else begin
                    in_d1_d = in_img;
`ifdef FB_BORDER_EN
                    bd1_d   = border && !in_img;
                    color_d = in_d1_q ? ram_q : (bd1_q ? 8'hFF : 8'h00);
`else
                    color_d = in_d1_q ? ram_q : 8'h00;
`endif
                    if (in_img) begin
                        rd_addr_d = is_first ? row_base_q : rd_addr_q + ADDR_W'(1);
                        if (is_last) row_base_d = row_base_q + ADDR_W'(w_amp);
                    end
                    if (fs) row_base_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_lat_q <= seletor;
            x_off_q    <= off_x(seletor);
            y_off_q    <= off_y(seletor);
            row_base_q <= '0;
            rd_addr_q  <= '0;
            in_d1_q    <= 1'b0;
            in_d2_q    <= 1'b0;
            color_q    <= 8'h00;
`ifdef FB_BORDER_EN
            bd1_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_lat_q <= mode_lat_d;
            x_off_q    <= off_x(mode_lat_q);
            y_off_q    <= off_y(mode_lat_q);
            row_base_q <= row_base_d;
            rd_addr_q  <= rd_addr_d;
            in_d1_q    <= in_d1_d;
            in_d2_q    <= in_d2_d;
            color_q    <= color_d;
`ifdef FB_BORDER_EN
            bd1_q      <= bd1_d;
`endif
        end
    end

    assign rd_addr      = rd_addr_q;
    assign color_out    = color_q;
    assign frame_active = (state_q == SHOW);
    assign dbg_o        = {in_d2_q, in_d1_q, state_q};

endmodule

// File: tb/tb_fb_scaled_reader.sv
// Directed bench for fb_scaled_reader: coordinate scans per scale mode with probe tables
// holding hand-computed addresses and colours.
module tb_fb_scaled_reader;

  localparam int ADDR_W = 19;
  localparam logic [7:0] PIX = 8'h3C;
`ifdef FB_BORDER_EN
  localparam logic [7:0] RING = 8'hFF;
`else
  localparam logic [7:0] RING = 8'h00;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic [9:0] next_x, next_y;
  logic [1:0] seletor;
  logic copy_done;
  logic [7:0] ram_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] color_out;
  logic frame_active;
  logic [3:0] dbg_o;

  always #5 clk = ~clk;

  fb_scaled_reader dut (
    .clk(clk),
    .reset(reset),
    .next_x(next_x),
    .next_y(next_y),
    .seletor(seletor),
    .copy_done(copy_done),
    .ram_q(ram_q),
    .rd_addr(rd_addr),
    .color_out(color_out),
    .frame_active(frame_active),
    .dbg_o(dbg_o)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int x;
    int y;
    bit chk_a;
    int addr;
    bit chk_c;
    logic [7:0] col;
  } probe_t;

  probe_t probes[$];
  int px = -1;
  int py = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_probe(input int x, input int y, input bit ca, input int a,
                           input bit cc, input logic [7:0] c);
    probe_t p;
    p.x = x; p.y = y; p.chk_a = ca; p.addr = a; p.chk_c = cc; p.col = c;
    probes.push_back(p);
  endtask

  // driver: present one coordinate for one clock, then check probes
  task automatic present(input int x, input int y);
    next_x = 10'(x);
    next_y = 10'(y);
    @(posedge clk);
    #1;
    foreach (probes[i]) begin
      if (probes[i].chk_a && probes[i].x == x && probes[i].y == y)
        check_eq($sformatf("addr(%0d,%0d)", x, y), 32'(rd_addr), 32'(probes[i].addr));
      if (probes[i].chk_c && probes[i].x == px && probes[i].y == py)
        check_eq($sformatf("color(%0d,%0d)", px, py), 32'(color_out), 32'(probes[i].col));
    end
    px = x;
    py = y;
  endtask

  task automatic scan_row(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) present(x, y);
  endtask

  // full scans on the first two and the last window row; other rows only hit the row end
  task automatic window_frame(input int y_top, input int y_bot, input int x_lo,
                              input int x_hi, input int x_last);
    for (int y = y_top; y <= y_bot; y++) begin
      if (y == y_top || y == y_top + 1 || y == y_bot) scan_row(y, x_lo, x_hi);
      else present(x_last, y);
    end
    present(630, 470);
    present(630, 470);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    seletor = 2'b10;
    copy_done = 1'b0;
    ram_q = PIX;
    next_x = 10'd630;
    next_y = 10'd470;
    present(630, 470);
    present(630, 470);
    check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("rst_color", 32'(color_out), 32'd0);
    check_eq("rst_frame_active", 32'(frame_active), 32'd0);
    check_eq("rst_state", 32'(dbg_o[1:0]), 32'd0);
    reset = 1'b0;

    // mode 10: native 160x120 at (240,180)
    present(630, 470);
    check_eq("idle_no_copy", 32'(dbg_o[1:0]), 32'd0);
    copy_done = 1'b1;
    present(630, 470);
    check_eq("wait_state", 32'(dbg_o[1:0]), 32'd1);
    check_eq("wait_frame_active", 32'(frame_active), 32'd0);
    add_probe(240, 180, 1, 0, 1, PIX);
    add_probe(241, 180, 1, 1, 0, 8'h00);
    add_probe(399, 180, 1, 159, 0, 8'h00);
    add_probe(240, 181, 1, 160, 0, 8'h00);
    add_probe(239, 180, 1, 0, 1, RING);
    add_probe(400, 180, 1, 0, 1, RING);
    add_probe(238, 180, 0, 0, 1, 8'h00);
    add_probe(399, 299, 1, 19199, 1, PIX);
    add_probe(400, 299, 0, 0, 1, RING);
    present(0, 0);
    check_eq("show_state_m10", 32'(dbg_o[1:0]), 32'd2);
    check_eq("show_frame_active", 32'(frame_active), 32'd1);
    window_frame(180, 299, 238, 401, 399);

    // mid-frame mode change 10 -> 00
    probes.delete();
    present(0, 0);
    scan_row(180, 240, 250);
    check_eq("color_before_change", 32'(color_out), 32'(PIX));
    seletor = 2'b00;
    present(251, 180);
    check_eq("chg_state_idle", 32'(dbg_o[1:0]), 32'd0);
    check_eq("chg_color", 32'(color_out), 32'd0);
    check_eq("chg_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("chg_frame_active", 32'(frame_active), 32'd0);
    present(252, 180);
    check_eq("chg_state_wait", 32'(dbg_o[1:0]), 32'd1);
    check_eq("chg_color_next", 32'(color_out), 32'd0);

    // mode 00: 320x240 at (160,120)
    add_probe(160, 120, 1, 0, 1, PIX);
    add_probe(161, 120, 1, 1, 0, 8'h00);
    add_probe(479, 120, 1, 319, 0, 8'h00);
    add_probe(160, 121, 1, 320, 0, 8'h00);
    add_probe(158, 120, 0, 0, 1, 8'h00);
    add_probe(159, 120, 0, 0, 1, RING);
    add_probe(479, 359, 1, 76799, 1, PIX);
    add_probe(480, 359, 0, 0, 1, RING);
    present(0, 0);
    check_eq("show_state_m00", 32'(dbg_o[1:0]), 32'd2);
    window_frame(120, 359, 158, 481, 479);

    // mode 01: 80x60 at (280,210)
    probes.delete();
    seletor = 2'b01;
    present(630, 470);
    present(630, 470);
    add_probe(280, 210, 1, 0, 1, PIX);
    add_probe(359, 210, 1, 79, 0, 8'h00);
    add_probe(280, 211, 1, 80, 0, 8'h00);
    add_probe(279, 210, 0, 0, 1, RING);
    add_probe(278, 210, 0, 0, 1, 8'h00);
    add_probe(359, 269, 1, 4799, 1, PIX);
    add_probe(360, 269, 0, 0, 1, RING);
    present(0, 0);
    check_eq("show_state_m01", 32'(dbg_o[1:0]), 32'd2);
    window_frame(210, 269, 278, 361, 359);

    // copy_done low: nothing shown, raise mid-frame, display waits for the next (0,0)
    probes.delete();
    copy_done = 1'b0;
    present(630, 470);
    check_eq("nocopy_state", 32'(dbg_o[1:0]), 32'd0);
    present(0, 0);
    check_eq("nocopy_fs_state", 32'(dbg_o[1:0]), 32'd0);
    for (int x = 280; x <= 290; x++) add_probe(x, 210, 0, 0, 1, 8'h00);
    scan_row(210, 280, 283);
    copy_done = 1'b1;
    present(284, 210);
    check_eq("midframe_wait", 32'(dbg_o[1:0]), 32'd1);
    scan_row(210, 285, 291);
    check_eq("midframe_frame_active", 32'(frame_active), 32'd0);
    probes.delete();
    add_probe(280, 210, 1, 0, 1, PIX);
    present(0, 0);
    check_eq("resume_show", 32'(dbg_o[1:0]), 32'd2);
    scan_row(210, 278, 282);

    // copy_done rising together with fs only reaches WAIT_FRAME
    probes.delete();
    copy_done = 1'b0;
    present(630, 470);
    copy_done = 1'b1;
    present(0, 0);
    check_eq("simul_wait", 32'(dbg_o[1:0]), 32'd1);
    present(1, 0);
    present(0, 0);
    check_eq("simul_show_next_fs", 32'(dbg_o[1:0]), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
